// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: maps byte/half/word loads and stores onto four byte-wide memory lanes.
// Misaligned accesses are done in one pass: lanes below the offset use the next row.
module dmem_lane_ctrl #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        REQ_VALID,
    output logic                        REQ_READY,
    input  logic                        REQ_WE,
    input  logic [2:0]                  REQ_FUNCT3,
    input  logic [ADDR_WIDTH-1:0]       REQ_ADDR,
    input  logic [31:0]                 REQ_WDATA,
    output logic                        RSP_VALID,
    output logic [31:0]                 RSP_RDATA,
    output logic                        RSP_ERR,
    output logic [4*(ADDR_WIDTH-2)-1:0] MEM_ADDR,
    output logic [3:0]                  MEM_WE,
    output logic [3:0]                  MEM_RE,
    output logic [31:0]                 MEM_DIN,
    input  logic [31:0]                 MEM_DOUT
);
    localparam int RW = ADDR_WIDTH - 2;
    localparam logic [1:0] IDLE = 2'd0, RD_WAIT = 2'd1, RESP = 2'd2;
    logic [1:0]    state_q, state_d, off_q, off_d;
    logic [2:0]    f3_q, f3_d;
    logic          ld_q, ld_d, err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    off;
    logic [RW-1:0] row;
    logic          legal, accept;
    logic [3:0]    smask, lanes;
    logic [7:0]    rot8;
    logic [63:0]   w64, g64;
    logic [31:0]   bmask, g, ext;
    assign off       = REQ_ADDR[1:0];
    assign row       = REQ_ADDR[ADDR_WIDTH-1:2];
    assign legal     = REQ_FUNCT3 == 3'b000 || REQ_FUNCT3 == 3'b001 || REQ_FUNCT3 == 3'b010 ||
                       REQ_FUNCT3 == 3'b100 || REQ_FUNCT3 == 3'b101;
    assign REQ_READY = state_q == IDLE && !RST;
    assign accept    = REQ_VALID && REQ_READY;
    assign smask     = REQ_FUNCT3[1] ? 4'b1111 : REQ_FUNCT3[0] ? 4'b0011 : 4'b0001;
    // Rotating the size mask by the offset gives the lanes touched, wrapping past lane 3.
    assign rot8      = {4'b0, smask} << off;
    assign lanes     = rot8[3:0] | rot8[7:4];
    assign MEM_WE    = (accept && legal && REQ_WE) ? lanes : 4'b0;
    assign MEM_RE    = (accept && legal && !REQ_WE) ? lanes : 4'b0;
    assign w64       = {32'b0, REQ_WDATA} << {off, 3'b0};
    assign MEM_DIN   = (w64[31:0] | w64[63:32]) & bmask;
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_lane
            assign MEM_ADDR[i*RW +: RW] = row + RW'(2'(i) < off);
            assign bmask[i*8 +: 8]      = {8{MEM_WE[i]}};
        end
    endgenerate
    assign g64 = {MEM_DOUT, MEM_DOUT} >> {off_q, 3'b0};
    assign g   = g64[31:0];
    assign ext = f3_q == 3'b000 ? {{24{g[7]}}, g[7:0]} :
                 f3_q == 3'b001 ? {{16{g[15]}}, g[15:0]} :
                 f3_q == 3'b100 ? {24'b0, g[7:0]} :
                 f3_q == 3'b101 ? {16'b0, g[15:0]} : g;
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        f3_d    = f3_q;
        ld_d    = ld_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        if (accept) begin
            off_d   = off;
            f3_d    = REQ_FUNCT3;
            ld_d    = legal && !REQ_WE;
            err_d   = !legal;
            state_d = (legal && !REQ_WE) ? RD_WAIT : RESP;
        end else if (state_q == RD_WAIT) begin
            rdata_d = ext;
            state_d = RESP;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            off_q   <= 2'b0;
            f3_q    <= 3'b0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end
    assign RSP_VALID = state_q == RESP;
    // The last load result is kept, but store and error responses present zero.
    assign RSP_RDATA = (state_q == RESP && !ld_q) ? 32'b0 : rdata_q;
    assign RSP_ERR   = err_q;
endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// tb_dmem_lane_ctrl: directed vectors against a four-lane byte memory with registered reads.
module tb_dmem_lane_ctrl;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        REQ_VALID = 1'b0, REQ_WE = 1'b0, REQ_READY;
    logic [2:0]  REQ_FUNCT3 = 3'b0;
    logic [7:0]  REQ_ADDR = 8'b0;
    logic [31:0] REQ_WDATA = 32'b0, RSP_RDATA, MEM_DIN, MEM_DOUT;
    logic        RSP_VALID, RSP_ERR;
    logic [23:0] MEM_ADDR;
    logic [3:0]  MEM_WE, MEM_RE;
    int          n_run = 0, n_fail = 0;
    logic [7:0]  mem [4][64];

    dmem_lane_ctrl #(.ADDR_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WE(REQ_WE), .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_DIN(MEM_DIN),
        .MEM_DOUT(MEM_DOUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK)
        for (int l = 0; l < 4; l++) begin
            if (MEM_WE[l]) mem[l][MEM_ADDR[l*6 +: 6]] <= MEM_DIN[l*8 +: 8];
            if (MEM_RE[l]) MEM_DOUT[l*8 +: 8] <= mem[l][MEM_ADDR[l*6 +: 6]];
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic acc(input string tag, input logic we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, input logic [3:0] xwe, input logic [3:0] xre,
                       input logic ca, input logic [23:0] xaddr, input logic [31:0] xdin,
                       input logic [31:0] xrd, input logic xerr);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = a; REQ_WDATA = wd;
        #1;
        chk({tag, ".ready"}, 32'(REQ_READY), 32'd1);
        chk({tag, ".we"}, 32'(MEM_WE), 32'(xwe));
        chk({tag, ".re"}, 32'(MEM_RE), 32'(xre));
        if (ca) chk({tag, ".addr"}, 32'(MEM_ADDR), 32'(xaddr));
        if (we) chk({tag, ".din"}, MEM_DIN, xdin);
        tick;
        chk({tag, ".busy_ready"}, 32'(REQ_READY), 32'd0);
        chk({tag, ".busy_strb"}, 32'({MEM_WE, MEM_RE}), 32'd0);
        if (xre != 4'b0) begin
            chk({tag, ".wait_valid"}, 32'(RSP_VALID), 32'd0);
            tick;
        end
        chk({tag, ".rsp_valid"}, 32'(RSP_VALID), 32'd1);
        chk({tag, ".rdata"}, RSP_RDATA, xrd);
        chk({tag, ".err"}, 32'(RSP_ERR), 32'(xerr));
        tick;
        REQ_VALID = 1'b0;
        chk({tag, ".pulse_end"}, 32'(RSP_VALID), 32'd0);
    endtask

    initial begin
        REQ_VALID = 1'b1;
        tick; tick;
        #1;
        chk("rst.ready", 32'(REQ_READY), 32'd0);
        chk("rst.strb", 32'({MEM_WE, MEM_RE}), 32'd0);
        chk("rst.valid", 32'(RSP_VALID), 32'd0);
        chk("rst.rdata", RSP_RDATA, 32'd0);
        chk("rst.err", 32'(RSP_ERR), 32'd0);
        REQ_VALID = 1'b0;
        RST = 1'b0;
        tick;
        acc("sw10", 1, 3'b010, 8'h10, 32'hDEADBEEF, 4'b1111, 4'b0, 1, 24'h104104, 32'hDEADBEEF, 32'h0, 0);
        acc("lw10", 0, 3'b010, 8'h10, 32'h0, 4'b0, 4'b1111, 1, 24'h104104, 32'h0, 32'hDEADBEEF, 0);
        acc("lh10", 0, 3'b001, 8'h10, 32'h0, 4'b0, 4'b0011, 0, 24'h0, 32'h0, 32'hFFFFBEEF, 0);
        acc("lhu11", 0, 3'b101, 8'h11, 32'h0, 4'b0, 4'b0110, 0, 24'h0, 32'h0, 32'h0000ADBE, 0);
        acc("sb21", 1, 3'b000, 8'h21, 32'h12345680, 4'b0010, 4'b0, 1, 24'h208209, 32'h00008000, 32'h0, 0);
        acc("lb21", 0, 3'b000, 8'h21, 32'h0, 4'b0, 4'b0010, 0, 24'h0, 32'h0, 32'hFFFFFF80, 0);
        acc("lbu21", 0, 3'b100, 8'h21, 32'h0, 4'b0, 4'b0010, 0, 24'h0, 32'h0, 32'h00000080, 0);
        acc("sw13", 1, 3'b010, 8'h13, 32'h44332211, 4'b1111, 4'b0, 1, 24'h105145, 32'h11443322, 32'h0, 0);
        acc("lw13", 0, 3'b010, 8'h13, 32'h0, 4'b0, 4'b1111, 1, 24'h105145, 32'h0, 32'h44332211, 0);
        acc("sbff", 1, 3'b000, 8'hFF, 32'h00000034, 4'b1000, 4'b0, 0, 24'h0, 32'h34000000, 32'h0, 0);
        acc("sb00", 1, 3'b000, 8'h00, 32'h00000092, 4'b0001, 4'b0, 0, 24'h0, 32'h00000092, 32'h0, 0);
        acc("lhff", 0, 3'b001, 8'hFF, 32'h0, 4'b0, 4'b1001, 1, 24'hFC0000, 32'h0, 32'hFFFF9234, 0);
        acc("ill011", 1, 3'b011, 8'h10, 32'hCAFEF00D, 4'b0, 4'b0, 0, 24'h0, 32'h0, 32'h0, 1);
        acc("ill110", 0, 3'b110, 8'h10, 32'h0, 4'b0, 4'b0, 0, 24'h0, 32'h0, 32'h0, 1);
        acc("sb_err_clr", 1, 3'b000, 8'h30, 32'h000000AA, 4'b0001, 4'b0, 0, 24'h0, 32'h000000AA, 32'h0, 0);
        REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 8'h10;
        tick;
        REQ_VALID = 1'b0;
        RST = 1'b1;
        REQ_VALID = 1'b1;
        #1;
        chk("rstw.ready", 32'(REQ_READY), 32'd0);
        chk("rstw.strb", 32'({MEM_WE, MEM_RE}), 32'd0);
        tick;
        chk("rstw.valid", 32'(RSP_VALID), 32'd0);
        REQ_VALID = 1'b0;
        RST = 1'b0;
        #1;
        chk("rstw.ready_after", 32'(REQ_READY), 32'd1);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("rstw.no_rsp", 32'(RSP_VALID), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_lane_ctrl.md
DMEM_LANE_CTRL -- requirements
Module: dmem_lane_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning byte-address width; lane row width is ADDR_WIDTH-2.
REQ-002 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port REQ_VALID  input  1  pipeline access request.
REQ-005 SHALL have port REQ_READY  output  1  controller can accept a request.
REQ-006 SHALL have port REQ_WE  input  1  1 = store, 0 = load.
REQ-007 SHALL have port REQ_FUNCT3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port REQ_ADDR  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port REQ_WDATA  input  32  store data, right-aligned.
REQ-010 SHALL have port RSP_VALID  output  1  one-cycle completion pulse.
REQ-011 SHALL have port RSP_RDATA  output  32  load result, extended.
REQ-012 SHALL have port RSP_ERR  output  1  illegal funct3; valid with RSP_VALID.
REQ-013 SHALL have port MEM_ADDR  output  4*(ADDR_WIDTH-2)  per-lane row; lane i at bits [i*(ADDR_WIDTH-2) +: ADDR_WIDTH-2]; drives both W_ADDR and R_ADDR of lane i.
REQ-014 SHALL have port MEM_WE  output  4  per-lane write enable.
REQ-015 SHALL have port MEM_RE  output  4  per-lane read enable.
REQ-016 SHALL have port MEM_DIN  output  32  lane i data at bits [8i+7:8i].
REQ-017 SHALL have port MEM_DOUT  input  32  lane i registered read data at [8i+7:8i], valid one cycle after MEM_RE.

Function
REQ-018 SHALL implement states IDLE, RD_WAIT, RESP.
REQ-019 SHALL assert REQ_READY only in IDLE; accept = REQ_VALID && REQ_READY.
REQ-020 SHALL define off = REQ_ADDR[1:0], row = REQ_ADDR[ADDR_WIDTH-1:2], size = 1/2/4 bytes for B-BU/H-HU/W.
REQ-021 SHALL map byte k (k < size) to lane (off+k) mod 4; lane i row = row+1 if i < off, else row; row+1 wraps modulo 2^(ADDR_WIDTH-2); all accesses are single-pass, including misaligned.
REQ-022 SHALL, on accepted store, drive MEM_WE, MEM_DIN, MEM_ADDR combinationally in the accept cycle, with MEM_WE set only for the size lanes; non-selected lanes keep MEM_DIN = 0; next state RESP.
REQ-023 SHALL, on accepted load, drive MEM_RE for the size lanes in the accept cycle; next state RD_WAIT.
REQ-024 SHALL, in RD_WAIT, gather byte k from lane (off+k) mod 4 of MEM_DOUT using registered off/funct3; sign-extend for B/H, zero-extend for BU/HU; register into RSP_RDATA; next state RESP.
REQ-025 SHALL, in RESP, assert RSP_VALID for one cycle; next state IDLE. Store latency: accept at T, RSP_VALID at T+1. Load latency: accept at T, RSP_VALID at T+2.
REQ-026 SHALL hold RSP_RDATA until the next load completes; RSP_RDATA SHALL be 0 on store responses.
REQ-027 SHALL treat an illegal funct3 (011, 110, 111) as no memory access, with MEM_WE = MEM_RE = 0, going to RESP with RSP_ERR = 1 and RSP_RDATA = 0.
REQ-028 SHALL keep MEM_WE and MEM_RE at 0 in any cycle without an accept; REQ_VALID outside IDLE is ignored.

Reset
REQ-029 SHALL, with RST high at a clock edge, force state IDLE, RSP_VALID = 0, RSP_RDATA = 0, RSP_ERR = 0 and the registered off/funct3 to 0.
REQ-030 SHALL gate MEM_WE, MEM_RE and REQ_READY to 0 while RST is high.
REQ-031 SHALL discard any in-flight load or pending response on RST; no RSP_VALID follows.

Verification
REQ-032 SW at 0x10 of 0xDEADBEEF -> MEM_WE = 1111, all rows 4, MEM_DIN = 0xDEADBEEF; then LW 0x10 -> RSP_VALID at T+2, RSP_RDATA = 0xDEADBEEF.
REQ-033 Lanes hold 0x80 at byte 0x21 -> LB 0x21 gives 0xFFFFFF80; LBU 0x21 gives 0x00000080; MEM_RE = 0010.
REQ-034 Misaligned SW 0x13 of 0x44332211 -> lane3 row 4 = 0x11, lanes 0/1/2 row 5 = 0x22/0x33/0x44; LW 0x13 returns 0x44332211.
REQ-035 ADDR_WIDTH = 8, LH at 0xFF -> lane 3 row 63 and lane 0 row 0 (wrap); bytes 0x34/0x92 give 0xFFFF9234.
REQ-036 funct3 = 011 -> no MEM_WE/MEM_RE, RSP_VALID at T+1 with RSP_ERR = 1; RST asserted in RD_WAIT -> no RSP_VALID, REQ_READY = 1 on first cycle after RST drops.
